// File: rtl/pixel_framebuffer_sink_pkg.sv
// Shared display definitions for the pixel frame-buffer path.
// Panel geometry, the sprite transparent colour, the RGB565 pixel type,
// the frame-buffer address width and the sink state encoding.
package pixel_framebuffer_sink_pkg;

  localparam int unsigned LCD_WIDTH  = 240;
  localparam int unsigned LCD_HEIGHT = 320;
  localparam int unsigned FB_ADDR_W  = 17;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t TRANSPARENT_COLOUR = 16'h0001;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_HOLD,
    ST_CLEAR
  } fb_state_e;

endpackage

// File: rtl/pixel_framebuffer_sink_if.sv
// Pixel-write handshake bus (initiator -> frame-buffer sink).
//   xAddr[7:0], yAddr[8:0], pixelData[15:0], pixelWrite : initiator outputs
//   pixelReady                                          : responder output
interface pixel_framebuffer_sink_if;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;

  modport master (output xAddr, output yAddr, output pixelData, output pixelWrite,
                  input  pixelReady);
  modport slave  (input  xAddr, input  yAddr, input  pixelData, input  pixelWrite,
                  output pixelReady);
endinterface

// File: rtl/pixel_framebuffer_sink_addr_calc.sv
// fb_addr_calc: combinational linear frame-buffer address y*WIDTH+x plus a
// range check on the raw coordinates.
//   x[7:0], y[8:0]  : pixel coordinates
//   addr[ADDR_W-1:0]: y*WIDTH+x at ADDR_W width
//   in_range        : x<WIDTH && y<HEIGHT
module fb_addr_calc #(
  parameter int unsigned WIDTH  = 240,
  parameter int unsigned HEIGHT = 320,
  parameter int unsigned ADDR_W = 17
) (
  input  logic [7:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext    = ADDR_W'(x);
  assign y_ext    = ADDR_W'(y);
  assign in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);

  generate
    if (WIDTH == 240) begin : g_shift_add
      // 240*y = 256*y - 16*y
      assign addr = (y_ext << 8) - (y_ext << 4) + x_ext;
    end else begin : g_mul
      assign addr = y_ext * ADDR_W'(WIDTH) + x_ext;
    end
  endgenerate

endmodule

// File: rtl/pixel_framebuffer_sink.sv
// pixel_framebuffer_sink: responder end of the pixel-write bus. Accepted
// pixels are written into a WIDTH x HEIGHT RGB565 frame buffer through a
// single-port RAM write port; a clear sequencer fills the whole screen.
//   clock, reset       : system clock, asynchronous active-high reset
//   pix (slave)        : xAddr/yAddr/pixelData/pixelWrite in, pixelReady out
//   clearReq           : start full-screen fill (sampled in IDLE only)
//   clearColour        : fill colour, latched at clear start
//   ramAddr/ramData/ramWe : RAM write port, ramWe pulses one cycle per write
//   busy               : high in WRITE, HOLD and CLEAR
//   rangeError         : one-cycle pulse when an out-of-range pixel is dropped
// Optional: define PIXEL_FRAMEBUFFER_COLOUR_KEY_EN to drop pixels whose colour
// is TRANSPARENT_COLOUR (handshake unchanged, no write, no rangeError).
module pixel_framebuffer_sink
  import pixel_framebuffer_sink_pkg::*;
#(
  parameter int unsigned WIDTH        = LCD_WIDTH,
  parameter int unsigned HEIGHT       = LCD_HEIGHT,
  parameter int unsigned WRITE_CYCLES = 2,
  parameter int unsigned ADDR_W       = FB_ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset,
  pixel_framebuffer_sink_if.slave  pix,
  input  logic                     clearReq,
  input  logic [15:0]              clearColour,
  output logic [ADDR_W-1:0]        ramAddr,
  output logic [15:0]              ramData,
  output logic                     ramWe,
  output logic                     busy,
  output logic                     rangeError
);

  localparam int unsigned TOTAL  = WIDTH * HEIGHT;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = $clog2(WRITE_CYCLES + 1);

  fb_state_e         state_q, state_d;
  logic [7:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  rgb565_t           data_q, data_d;
  rgb565_t           colour_q, colour_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  rgb565_t           ram_data_q, ram_data_d;
  logic              ram_we_q, ram_we_d;
  logic              range_err_q, range_err_d;

  logic [ADDR_W-1:0] calc_addr;
  logic              calc_in_range;
  logic              keyed;

  fb_addr_calc #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .x        (x_q),
    .y        (y_q),
    .addr     (calc_addr),
    .in_range (calc_in_range)
  );

`ifdef PIXEL_FRAMEBUFFER_COLOUR_KEY_EN
  assign keyed = (data_q == TRANSPARENT_COLOUR);
`else
  assign keyed = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    data_d      = data_q;
    colour_d    = colour_q;
    clr_cnt_d   = clr_cnt_q;
    hold_d      = hold_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_we_d    = 1'b0;
    range_err_d = 1'b0;

    unique case (state_q)
      ST_INIT: state_d = ST_IDLE;

      ST_IDLE: begin
        if (clearReq) begin
          colour_d   = clearColour;
          ram_addr_d = '0;
          clr_cnt_d  = '0;
          state_d    = ST_CLEAR;
        end else if (pix.pixelWrite) begin
          x_d     = pix.xAddr;
          y_d     = pix.yAddr;
          data_d  = pix.pixelData;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (keyed) begin
          // transparent pixel: leave the background untouched
        end else if (calc_in_range) begin
          ram_addr_d = calc_addr;
          ram_data_d = data_q;
          ram_we_d   = 1'b1;
        end else begin
          range_err_d = 1'b1;
        end
        // WRITE itself is the first ready-low cycle, so HOLD covers the rest.
        if (WRITE_CYCLES <= 1) begin
          state_d = ST_IDLE;
        end else begin
          hold_d  = HOLD_W'(WRITE_CYCLES - 1);
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (hold_q <= HOLD_W'(1)) state_d = ST_IDLE;
        else                      hold_d  = hold_q - HOLD_W'(1);
      end

      ST_CLEAR: begin
        // Registered write port: the final address is presented while still
        // in CLEAR, so IDLE follows one cycle after clr_cnt reaches TOTAL.
        if (clr_cnt_q == CNT_W'(TOTAL)) begin
          state_d = ST_IDLE;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = clr_cnt_q[ADDR_W-1:0];
          ram_data_d = colour_q;
          clr_cnt_d  = clr_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      x_q         <= '0;
      y_q         <= '0;
      data_q      <= '0;
      colour_q    <= '0;
      clr_cnt_q   <= '0;
      hold_q      <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      data_q      <= data_d;
      colour_q    <= colour_d;
      clr_cnt_q   <= clr_cnt_d;
      hold_q      <= hold_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_we_q    <= ram_we_d;
      range_err_q <= range_err_d;
    end
  end

  assign pix.pixelReady = (state_q == ST_IDLE);
  assign busy           = (state_q == ST_WRITE) || (state_q == ST_HOLD) || (state_q == ST_CLEAR);
  assign ramAddr        = ram_addr_q;
  assign ramData        = ram_data_q;
  assign ramWe          = ram_we_q;
  assign rangeError     = range_err_q;

endmodule

// File: tb/tb_pixel_framebuffer_sink.sv
// Testbench for pixel_framebuffer_sink: directed steps plus randomized pixel
// writes, checked against a coordinate-level reference model of the frame
// buffer writes. Honours PIXEL_FRAMEBUFFER_COLOUR_KEY_EN when defined.
module tb_pixel_framebuffer_sink;

  localparam int W  = 240;
  localparam int H  = 320;
  localparam int WC = 2;

  typedef struct packed {
    logic        err;
    logic [16:0] addr;
    logic [15:0] data;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clearReq = 1'b0;
  logic [15:0] clearColour = '0;
  logic [16:0] ramAddr;
  logic [15:0] ramData;
  logic        ramWe;
  logic        busy;
  logic        rangeError;

  pixel_framebuffer_sink_if pif();

  pixel_framebuffer_sink #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .WRITE_CYCLES (WC),
    .ADDR_W       (17)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pix         (pif),
    .clearReq    (clearReq),
    .clearColour (clearColour),
    .ramAddr     (ramAddr),
    .ramData     (ramData),
    .ramWe       (ramWe),
    .busy        (busy),
    .rangeError  (rangeError)
  );

  always #5 clock = ~clock;

  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  ev_t act_q[$];
  int  act_c[$];
  ev_t exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Observed RAM-port activity, sampled mid-cycle.
  always @(negedge clock) begin
    if (ramWe === 1'b1) begin
      act_q.push_back('{err: 1'b0, addr: ramAddr, data: ramData});
      act_c.push_back(cyc);
    end
    if (rangeError === 1'b1) begin
      act_q.push_back('{err: 1'b1, addr: '0, data: '0});
      act_c.push_back(cyc);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: what the frame buffer should see for one accepted pixel.
  task automatic model_pixel(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
    ev_t e;
`ifdef PIXEL_FRAMEBUFFER_COLOUR_KEY_EN
    if (d == 16'h0001) return;
`endif
    if (int'(x) < W && int'(y) < H) begin
      e.err = 1'b0; e.addr = 17'(int'(y) * W + int'(x)); e.data = d;
    end else begin
      e.err = 1'b1; e.addr = '0; e.data = '0;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_clear(input logic [15:0] colour, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{err: 1'b0, addr: 17'(i), data: colour});
  endtask

  task automatic check_events(input string tag);
    int bad = -1;
    chk({tag, "_event_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && act_q[i] !== exp_q[i]) bad = i;
    chk({tag, "_first_bad_event"}, bad, -1);
    act_q.delete(); act_c.delete(); exp_q.delete();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clock);
    while (pif.pixelReady !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    chk({tag, "_ready"}, pif.pixelReady, 1'b1);
  endtask

  // Called at the negedge before an accepting posedge with pixelWrite high.
  task automatic handshake_once(input logic [7:0] x, input logic [8:0] y,
                                input logic [15:0] d, input bit scramble);
    int low = 0;
    @(negedge clock);
    chk("ready_fall", pif.pixelReady, 1'b0);
    chk("busy_after_accept", busy, 1'b1);
    if (scramble) begin
      pif.xAddr = 8'($urandom); pif.yAddr = 9'($urandom); pif.pixelData = 16'($urandom);
    end
    while (pif.pixelReady === 1'b0 && low < 20) begin low++; @(negedge clock); end
    chk("ready_low_cycles", low, WC);
    model_pixel(x, y, d);
  endtask

  task automatic write_pixel(input logic [7:0] x, input logic [8:0] y,
                             input logic [15:0] d, input int reps);
    wait_ready("pre_write");
    pif.xAddr = x; pif.yAddr = y; pif.pixelData = d; pif.pixelWrite = 1'b1;
    for (int r = 0; r < reps; r++) handshake_once(x, y, d, reps == 1);
    pif.pixelWrite = 1'b0;
  endtask

  initial begin
    int low;
    int bad;
    int found;
    pif.xAddr = '0; pif.yAddr = '0; pif.pixelData = '0; pif.pixelWrite = 1'b0;

    // Reset values
    @(negedge clock);
    chk("rst_ready", pif.pixelReady, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", ramWe, 1'b0);
    chk("rst_rangeerr", rangeError, 1'b0);
    chk("rst_addr", ramAddr, 17'd0);
    chk("rst_data", ramData, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("init_ready", pif.pixelReady, 1'b0);
    chk("init_busy", busy, 1'b0);
    @(negedge clock);
    chk("idle_ready", pif.pixelReady, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // Held pixelWrite: accepted twice, same address and data
    write_pixel(8'd5, 9'd3, 16'hF800, 2);
    chk("t1_model_addr", exp_q[0].addr, 17'd725);
    check_events("held_write");

    // Corner pixels
    write_pixel(8'd0, 9'd0, 16'h1234, 1);
    write_pixel(8'd239, 9'd319, 16'hBEEF, 1);
    check_events("corners");

    // Out-of-range coordinates
    write_pixel(8'd240, 9'd0, 16'h5555, 1);
    write_pixel(8'd0, 9'd320, 16'hAAAA, 1);
    write_pixel(8'd255, 9'd511, 16'h0F0F, 1);
    check_events("range");

    // Transparent colour
    write_pixel(8'd10, 9'd10, 16'h0001, 1);
    check_events("colour_key");

    // Randomized writes
    for (int i = 0; i < 60; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
      write_pixel(8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)), d,
                  ($urandom_range(0, 4) == 0) ? 2 : 1);
    end
    check_events("random");

    // Clear and pixel write in the same IDLE cycle: clear wins
    wait_ready("pre_clear");
    pif.xAddr = 8'd7; pif.yAddr = 9'd7; pif.pixelData = 16'hABCD; pif.pixelWrite = 1'b1;
    clearReq = 1'b1; clearColour = 16'h001F;
    @(negedge clock);
    chk("clear_ready_low", pif.pixelReady, 1'b0);
    chk("clear_busy", busy, 1'b1);
    chk("clear_start_addr", ramAddr, 17'd0);
    clearReq = 1'b0; clearColour = 16'hFFFF;
    low = 1;
    while (pif.pixelReady === 1'b0 && low < 80000) begin
      @(negedge clock);
      if (pif.pixelReady === 1'b0) low++;
    end
    chk("clear_ready_low_cycles", low, W * H + 1);
    chk("clear_final_addr_hold", ramAddr, 17'd76799);
    chk("clear_end_busy", busy, 1'b0);
    model_clear(16'h001F, W * H);
    handshake_once(8'd7, 9'd7, 16'hABCD, 1'b1);
    pif.pixelWrite = 1'b0;
    bad = -1;
    for (int i = 1; i < W * H && i < act_c.size(); i++)
      if (bad < 0 && act_c[i] != act_c[i-1] + 1) bad = i;
    chk("clear_consecutive", bad, -1);
    check_events("clear");

    // Reset in the middle of a clear
    wait_ready("pre_partial_clear");
    clearReq = 1'b1; clearColour = 16'h07E0;
    @(negedge clock);
    clearReq = 1'b0;
    found = 0;
    for (int n = 0; n < 2000 && found == 0; n++) begin
      if (ramWe === 1'b1 && ramAddr === 17'd1000) found = 1;
      else @(negedge clock);
    end
    chk("partial_clear_reached_1000", found, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_we", ramWe, 1'b0);
    chk("abort_ready", pif.pixelReady, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_addr", ramAddr, 17'd0);
    model_clear(16'h07E0, 1001);
    check_events("partial_clear");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("post_reset_init_ready", pif.pixelReady, 1'b0);
    @(negedge clock);
    chk("post_reset_idle_ready", pif.pixelReady, 1'b1);
    repeat (20) @(negedge clock);
    check_events("no_resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
